// File: rtl/shared_vc_slot_allocator.sv
// shared_vc_slot_allocator
// Hands out the shared VC slots of one memory bank to the input VCs of the
// port that currently owns the bank. Round-robin among requesters, lowest
// free slot first, occupancy and owner tracking, sticky protocol error.
// Optional feature macro: SHARED_VC_STARVATION_EN (saturating per-requester
// wait counters; a saturated requester overrides round-robin).
module shared_vc_slot_allocator #(
    parameter int unsigned num_reqs         = 4,
    parameter int unsigned num_vcs_per_bank = 2,
    parameter int unsigned slot_idx_width   = 1,
    parameter int unsigned counter_width    = 4,
    localparam int unsigned req_idx_width   = (num_reqs > 1) ? $clog2(num_reqs) : 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      bank_grant,
    input  logic                                      ready_for_allocation,
    input  logic [num_reqs-1:0]                       req,
    input  logic                                      release_valid,
    input  logic [slot_idx_width-1:0]                 release_slot,
    output logic [num_reqs-1:0]                       gnt,
    output logic                                      gnt_valid,
    output logic [slot_idx_width-1:0]                 gnt_slot,
    output logic [num_vcs_per_bank-1:0]               slot_busy,
    output logic [num_vcs_per_bank*req_idx_width-1:0] slot_owner,
    output logic                                      all_free,
    output logic                                      protocol_error
);

    logic [req_idx_width-1:0]                 rr_ptr;
    logic [req_idx_width-1:0]                 rr_ptr_next;
    logic [num_vcs_per_bank-1:0]              slot_busy_next;
    logic [num_vcs_per_bank*req_idx_width-1:0] slot_owner_next;
    logic                                     protocol_error_next;

    logic                                     en;
    logic                                     any_free;
    logic [slot_idx_width-1:0]                free_idx;
    logic                                     rr_found;
    logic [req_idx_width-1:0]                 rr_idx;
    logic                                     winner_found;
    logic [req_idx_width-1:0]                 winner_idx;
    logic                                     release_in_range;
    logic                                     release_ok;
    logic                                     release_bad;

    // Lowest-index free slot; scanned downwards so the lowest match wins.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int s = int'(num_vcs_per_bank) - 1; s >= 0; s--) begin
            if (!slot_busy[s]) begin
                any_free = 1'b1;
                free_idx = slot_idx_width'(s);
            end
        end
    end

    // Grants are only possible inside the allocation window with a free slot.
    assign en = ~reset & bank_grant & ready_for_allocation & any_free;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned cand;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int unsigned k = 0; k < num_reqs; k++) begin
            cand = (32'(rr_ptr) + k) % num_reqs;
            if (!rr_found && req[req_idx_width'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = req_idx_width'(cand);
            end
        end
    end

`ifdef SHARED_VC_STARVATION_EN
    logic [counter_width-1:0] wait_cnt [num_reqs];
    logic [num_reqs-1:0]      starved;
    logic                     st_found;
    logic [req_idx_width-1:0] st_idx;

    // A requester is starved while it still requests and its counter is saturated.
    always_comb begin
        for (int r = 0; r < int'(num_reqs); r++) begin
            starved[r] = req[r] & (&wait_cnt[r]);
        end
    end

    // Lowest-index starved requester beats round-robin.
    always_comb begin
        st_found = 1'b0;
        st_idx   = '0;
        for (int r = int'(num_reqs) - 1; r >= 0; r--) begin
            if (starved[r]) begin
                st_found = 1'b1;
                st_idx   = req_idx_width'(r);
            end
        end
    end

    assign winner_found = st_found | rr_found;
    assign winner_idx   = st_found ? st_idx : rr_idx;

    // Saturating wait counters: count unserved request cycles, clear otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < int'(num_reqs); r++) begin
                wait_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < int'(num_reqs); r++) begin
                if (!req[r] || gnt[r]) begin
                    wait_cnt[r] <= '0;
                end else if (!(&wait_cnt[r])) begin
                    wait_cnt[r] <= wait_cnt[r] + counter_width'(1);
                end
            end
        end
    end
`else
    logic unused_counter_cfg;
    assign unused_counter_cfg = |counter_width;
    assign winner_found       = rr_found;
    assign winner_idx         = rr_idx;
`endif

    // Combinational grant towards the input VCs.
    always_comb begin
        gnt_valid = en & winner_found;
        gnt       = '0;
        gnt_slot  = '0;
        if (gnt_valid) begin
            gnt      = num_reqs'(1) << winner_idx;
            gnt_slot = free_idx;
        end
    end

    // Release classification: a good release returns a busy, in-range slot.
    always_comb begin
        release_in_range = 32'(release_slot) < num_vcs_per_bank;
        release_ok       = release_valid & release_in_range & slot_busy[release_slot];
        release_bad      = release_valid & ~release_ok;
    end

    // Next occupancy/owner/pointer state; release and grant touch different slots.
    always_comb begin
        slot_busy_next      = slot_busy;
        slot_owner_next     = slot_owner;
        rr_ptr_next         = rr_ptr;
        protocol_error_next = protocol_error | release_bad;
        if (release_ok) begin
            slot_busy_next[release_slot] = 1'b0;
        end
        if (gnt_valid) begin
            slot_busy_next[gnt_slot] = 1'b1;
            slot_owner_next[32'(gnt_slot)*req_idx_width +: req_idx_width] = winner_idx;
            if (32'(winner_idx) == num_reqs - 1) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = winner_idx + req_idx_width'(1);
            end
        end
    end

    // State registers; reset frees every slot immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_busy      <= '0;
            slot_owner     <= '0;
            rr_ptr         <= '0;
            protocol_error <= 1'b0;
        end else begin
            slot_busy      <= slot_busy_next;
            slot_owner     <= slot_owner_next;
            rr_ptr         <= rr_ptr_next;
            protocol_error <= protocol_error_next;
        end
    end

    assign all_free = ~|slot_busy;

endmodule
